dff_load_arbiter: RTL and testbench
===================================

// Module: dff_load_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one load-enabled D register bank (WIDTH bits) among NREQ writers.
//  Picks one requester, drives the bank's load and D for exactly one clock, checks the captured Q,
//  then acks the winner and waits for it to drop its request.
//  Sits between requesting blocks and the shared DFF-with-load bank; sole driver of that bank's load and D.
// PARAMETERS
//  NREQ   4  number of requesters (>=2)
//  WIDTH  8  data width of the shared register bank
//  IDW    $clog2(NREQ)  width of requester index (localparam, derived)
// PORTS
//  clk       in   1           rising-edge clock
//  reset     in   1           asynchronous, active-low reset (0 = reset)
//  req       in   NREQ        per-requester write request, level, held until ack
//  wdata     in   NREQ*WIDTH  requester i data on wdata[i*WIDTH +: WIDTH]
//  reg_q     in   WIDTH       Q readback from shared register bank
//  reg_load  out  1           load enable to register bank
//  reg_d     out  WIDTH       D to register bank
//  gnt       out  NREQ        one-hot grant, high from LOAD through RELEASE
//  ack       out  NREQ        one-hot, single-cycle write-complete pulse
//  err       out  1           single-cycle pulse with ack if reg_q != written data
//  busy      out  1           high in any state other than IDLE
//  last_id   out  IDW         index of most recently granted requester
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, ptr=0, reg_load=0, reg_d=0, gnt=0, ack=0, err=0, last_id=0.
//   Reset asserted mid-transfer aborts it immediately; no ack; bank contents untouched by this block.
//  All outputs registered (except busy, decoded from state).
//  FSM: IDLE -> LOAD -> CHECK -> RELEASE -> IDLE.
//   IDLE: if |req, choose first i with req[i]=1 searching ptr, ptr+1, ... wrapping NREQ-1 -> 0.
//     On that edge: gnt<=onehot(i), last_id<=i, reg_d<=wdata[i], reg_load<=1, ptr<=(i+1) mod NREQ,
//     state<=LOAD. No req: stay IDLE, all outputs hold 0 except reg_d/last_id (hold).
//   LOAD: reg_load=1 for this one cycle; bank captures reg_d on next edge. Edge: reg_load<=0, state<=CHECK.
//   CHECK: reg_q now holds written value. Edge: ack<=gnt, err<=(reg_q!=reg_d), state<=RELEASE.
//   RELEASE: ack/err high for first cycle only (cleared next edge). Stay until req[last_id]==0;
//     on that edge gnt<=0, state<=IDLE. If req still high, gnt stays, no re-grant.
//  Latency: req sampled at edge E0 in IDLE -> reg_load high E0..E1 -> bank updated at E1
//   -> ack high E2..E3. Minimum spacing between grants 4 cycles (IDLE,LOAD,CHECK,RELEASE).
//  Data latched at grant edge; wdata/req changes after grant do not affect the write in progress.
//  Requester dropping req during LOAD/CHECK: write still completes and acks; RELEASE exits next edge.
//  Other reqs arriving while busy wait; no request is lost while held (level-sensitive).
//  Fairness: with all NREQ requesting continuously, grant order is 0,1,..,NREQ-1,0,... (wrap).
//  Only one bit of gnt, ack ever set; reg_load never high outside LOAD.
// TESTING
//  1 Reset: reset=0 with req=4'b1111 -> all outputs 0, busy=0; release reset, req=0 -> stays IDLE.
//  2 Single write: req=4'b0100, wdata[2]=8'hA5 -> gnt=4'b0100, reg_load 1 cycle with reg_d=8'hA5,
//    ack=4'b0100 two cycles later, err=0, last_id=2; drop req -> IDLE next edge.
//  3 Round-robin wrap: req=4'b1111 held, each requester drops req 1 cycle after its ack then re-raises
//    -> grant order 0,1,2,3,0; ptr wraps 3->0.
//  4 Readback mismatch: bank model forces reg_q=8'h00 after writing 8'h3C -> err=1 coincident with ack.
//  5 Reset mid-op: assert reset during CHECK -> gnt/ack/reg_load 0 immediately, no ack after release,
//    next grant starts from requester 0.
//  6 Late data change: change wdata[1] 8'h11->8'h22 during LOAD -> bank holds 8'h11.

Source files
------------

// File: rtl/dff_load_arbiter.sv
// Round-robin sequencer that shares one load-enabled register bank among NREQ writers.
// Each transfer is a one-cycle load, a readback check, then ack and a wait for the winner to drop req.
module dff_load_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0]      reg_q,
    output logic                  reg_load,
    output logic [WIDTH-1:0]      reg_d,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  err,
    output logic                  busy,
    output logic [IDW-1:0]        last_id
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RELEASE
    } state_t;

    state_t            r_state;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_last_id;
    logic              r_load;
    logic [WIDTH-1:0]  r_d;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_ack;
    logic              r_err;

    logic              w_found;
    logic [IDW-1:0]    w_sel;
    logic [WIDTH-1:0]  w_data;
    logic [NREQ-1:0]   w_onehot;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        return IDW'(sum);
    endfunction

    // Search starts at r_ptr so the requester after the last winner has priority.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[wrap_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_sel   = wrap_idx(r_ptr, k);
            end
        end
    end

    assign w_data   = wdata[int'(w_sel)*WIDTH +: WIDTH];
    assign w_onehot = NREQ'(1) << w_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_last_id <= '0;
            r_load    <= 1'b0;
            r_d       <= '0;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt     <= w_onehot;
                        r_last_id <= w_sel;
                        r_d       <= w_data;
                        r_load    <= 1'b1;
                        r_ptr     <= wrap_idx(w_sel, 1);
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_load  <= 1'b0;
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_ack   <= r_gnt;
                    r_err   <= (reg_q != r_d);
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    r_ack <= '0;
                    r_err <= 1'b0;
                    // Hold the grant until the winner lets go, so it cannot be re-granted back-to-back.
                    if (!req[r_last_id]) begin
                        r_gnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign reg_load = r_load;
    assign reg_d    = r_d;
    assign gnt      = r_gnt;
    assign ack      = r_ack;
    assign err      = r_err;
    assign last_id  = r_last_id;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_dff_load_arbiter.sv
// Bench for dff_load_arbiter: vector table plus hand sequences, with an ack-driven scoreboard.
module tb_dff_load_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [WIDTH-1:0]      reg_q;
    logic                  reg_load;
    logic [WIDTH-1:0]      reg_d;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  err;
    logic                  busy;
    logic [IDW-1:0]        last_id;

    logic [WIDTH-1:0]      bank;
    logic                  force_zero;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        logic       err;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wdata;
        logic        fz;
        logic [1:0]  id;
        logic [7:0]  data;
        logic        err;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    dff_load_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .req      (req),
        .wdata    (wdata),
        .reg_q    (reg_q),
        .reg_load (reg_load),
        .reg_d    (reg_d),
        .gnt      (gnt),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .last_id  (last_id)
    );

    always #5 clk = ~clk;

    // Shared register bank model; force_zero corrupts the readback path.
    always_ff @(posedge clk) if (reg_load) bank <= reg_d;
    assign reg_q = force_zero ? '0 : bank;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer plus per-cycle invariants.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("gnt_onehot0", 32'($onehot0(gnt)), 1);
            check("ack_onehot0", 32'($onehot0(ack)), 1);
            check("load_only_busy", 32'(reg_load & ~busy), 0);
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_id", 32'(ack), 32'(4'b0001 << mon_e.id));
                    check("ack_gnt", 32'(gnt), 32'(4'b0001 << mon_e.id));
                    check("ack_last_id", 32'(last_id), 32'(mon_e.id));
                    check("ack_err", 32'(err), 32'(mon_e.err));
                    check("bank_data", 32'(bank), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic push_exp(input logic [1:0] id, input logic [7:0] data, input logic e_err);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.err  = e_err;
        sb.push_back(e);
    endtask

    // Starts and ends on a negedge with the DUT idle.
    task automatic run_vec(input vec_t v);
        req        = v.req;
        wdata      = v.wdata;
        force_zero = v.fz;
        push_exp(v.id, v.data, v.err);
        @(negedge clk);
        check("grant_gnt", 32'(gnt), 32'(4'b0001 << v.id));
        check("grant_load", 32'(reg_load), 1);
        check("grant_d", 32'(reg_d), 32'(v.data));
        check("grant_last_id", 32'(last_id), 32'(v.id));
        check("grant_busy", 32'(busy), 1);
        @(negedge clk);
        check("check_load_low", 32'(reg_load), 0);
        check("check_bank", 32'(bank), 32'(v.data));
        @(negedge clk);
        check("ack_timing", 32'(ack), 32'(4'b0001 << v.id));
        req        = '0;
        force_zero = 1'b0;
        @(negedge clk);
        check("release_busy", 32'(busy), 0);
        check("release_gnt", 32'(gnt), 0);
        check("release_ack", 32'(ack), 0);
        check("release_err", 32'(err), 0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] a;
        logic [1:0] id;
        rst_n      = 1'b0;
        req        = 4'b1111;
        wdata      = '0;
        force_zero = 1'b0;

        vecs[0] = '{4'b0100, 32'h11A52233, 1'b0, 2'd2, 8'hA5, 1'b0};
        vecs[1] = '{4'b0011, 32'h44556677, 1'b0, 2'd0, 8'h77, 1'b0};
        vecs[2] = '{4'b1001, 32'h8899AABB, 1'b0, 2'd3, 8'h88, 1'b0};
        vecs[3] = '{4'b0010, 32'h00003C00, 1'b1, 2'd1, 8'h3C, 1'b1};
        vecs[4] = '{4'b1111, 32'hDEADBEEF, 1'b0, 2'd2, 8'hAD, 1'b0};
        vecs[5] = '{4'b0001, 32'h01020304, 1'b0, 2'd0, 8'h04, 1'b0};

        // Reset holds everything at zero despite pending requests.
        repeat (2) @(negedge clk);
        check("rst_load", 32'(reg_load), 0);
        check("rst_d", 32'(reg_d), 0);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_last_id", 32'(last_id), 0);
        rst_n = 1'b1;
        req   = '0;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("idle_gnt", 32'(gnt), 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Data changed during LOAD must not reach the bank.
        req   = 4'b0010;
        wdata = 32'h00001100;
        push_exp(2'd1, 8'h11, 1'b0);
        @(negedge clk);
        check("late_load", 32'(reg_load), 1);
        wdata = 32'h00002200;
        @(negedge clk);
        check("late_bank", 32'(bank), 32'h11);
        @(negedge clk);
        check("late_ack", 32'(ack), 32'h2);
        req = '0;
        @(negedge clk);
        check("late_idle", 32'(busy), 0);

        // Reset during CHECK aborts the transfer and rewinds the pointer.
        req   = 4'b0100;
        wdata = 32'h005A0000;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_check", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_gnt", 32'(gnt), 0);
        check("abort_ack", 32'(ack), 0);
        check("abort_load", 32'(reg_load), 0);
        check("abort_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = '0;
        repeat (3) @(negedge clk);
        check("abort_no_ack", 32'(ack), 0);
        run_vec('{4'b1001, 32'h77000066, 1'b0, 2'd0, 8'h66, 1'b0});

        // Continuous requests rotate 0,1,2,3 and wrap back to 0.
        reset_pulse();
        req   = 4'b1111;
        wdata = 32'h43322110;
        for (int n = 0; n < 5; n++) begin
            id = 2'(n % 4);
            push_exp(id, 8'(16 + 17 * int'(id)), 1'b0);
            for (int k = 0; k < 12 && ack == '0; k++) @(negedge clk);
            if (ack == '0) begin
                check("rr_ack_timeout", 32'(ack), 32'(4'b0001 << id));
                void'(sb.pop_back());
            end else begin
                a = ack;
                @(negedge clk);
                req = req & ~a;
                @(negedge clk);
                req = 4'b1111;
            end
        end
        req = '0;
        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 0);
        check("final_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
